// File: rtl/get_bit.sv
// -----------------------------------------------------------------------------
// get_bit : MSB-first bitstream reader.
//
// Bytes from the slice byte source are appended to an MSB-aligned bit buffer.
// Entropy decoders ask for fields of 1..MAX_FIELD bits. A field comes back
// right-aligned on out_val, one cycle after its request is accepted.
// A MAX_FIELD-bit look-ahead window (peek) lets the decoders size their
// next request before they issue it.
//
// Optional feature macro: GET_BIT_LZC_EN
//   defined   : lzc is the registered leading-zero count of peek. It counts
//               only over valid bits and saturates at min(fill, MAX_FIELD).
//   undefined : lzc is tied to 0 and no counter logic is built.
//
// Parameter constraints: BUF_BITS is a multiple of 8, at least 40 and at
// most 127. The upper limit exists because fill is a 7-bit port.
// MAX_FIELD must stay 32 to match the 6-bit req_size/lzc ports.
// -----------------------------------------------------------------------------
module get_bit #(
   parameter int BUF_BITS  = 64,
   parameter int MAX_FIELD = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [7:0]           in_byte,
   output logic                 in_ready,
   input  logic                 req_valid,
   input  logic [5:0]           req_size,
   output logic                 req_ready,
   output logic                 out_valid,
   output logic [MAX_FIELD-1:0] out_val,
   output logic [MAX_FIELD-1:0] peek,
   output logic [6:0]           fill,
   output logic                 err,
   output logic [5:0]           lzc
);

   // Registered state. Unread bits sit at the top of buf_reg. Every bit
   // below the fill level is kept at zero, so peek needs no masking.
   logic [BUF_BITS-1:0]  buf_reg;
   logic [BUF_BITS-1:0]  buf_next;
   logic [6:0]           fill_reg;
   logic [6:0]           fill_next;
   logic                 out_valid_reg;
   logic [MAX_FIELD-1:0] out_val_reg;
   logic                 err_reg;
   logic                 err_next;
   logic [5:0]           lzc_reg;

   // Handshake decode.
   logic                 size_legal;
   logic                 req_fire;
   logic                 byte_fire;
   logic [6:0]           take;
   logic [6:0]           fill_after;
   logic [MAX_FIELD-1:0] window;
   logic [MAX_FIELD-1:0] field;
   logic [BUF_BITS-1:0]  byte_word;
   logic [BUF_BITS-1:0]  buf_shift;

   // Readiness and fire decode.
   // in_ready looks only at the registered fill level. It does not assume
   // that a consume in the same cycle will make room.
   always_comb begin
      size_legal = (req_size != 6'd0) && (req_size <= 6'(MAX_FIELD));
      in_ready   = (fill_reg <= 7'(BUF_BITS - 8));
      req_ready  = size_legal && (fill_reg >= {1'b0, req_size}) && !flush && !reset;
      req_fire   = req_valid && req_ready;
      // flush drops any byte offered in the same cycle.
      byte_fire  = in_valid && in_ready && !flush;
   end

   // Field extraction and buffer update.
   // The field is taken only from bits that were buffered before this cycle.
   // A byte accepted in the same cycle lands just after the bits that remain.
   always_comb begin
      take       = req_fire ? {1'b0, req_size} : 7'd0;
      fill_after = fill_reg - take;
      window     = buf_reg[BUF_BITS-1 -: MAX_FIELD];
      field      = window >> (6'(MAX_FIELD) - req_size);
      buf_shift  = buf_reg << take;
      byte_word  = {in_byte, {(BUF_BITS-8){1'b0}}} >> fill_after;

      buf_next  = buf_shift;
      fill_next = fill_after;
      if (byte_fire) begin
         buf_next  = buf_shift | byte_word;
         fill_next = fill_after + 7'd8;
      end
      if (flush) begin
         buf_next  = '0;
         fill_next = 7'd0;
      end
   end

   // Sticky error flag.
   // It is set by any request whose size is illegal. Only flush or reset
   // clears it.
   always_comb begin
      err_next = err_reg;
      if (req_valid && !size_legal)
         err_next = 1'b1;
      if (flush)
         err_next = 1'b0;
   end

   // Buffer, fill and error state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_reg  <= '0;
         fill_reg <= 7'd0;
         err_reg  <= 1'b0;
      end else begin
         buf_reg  <= buf_next;
         fill_reg <= fill_next;
         err_reg  <= err_next;
      end
   end

   // Field output: a one-cycle valid pulse. out_val keeps its last field
   // between pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_val_reg   <= '0;
      end else begin
         out_valid_reg <= req_fire;
         if (req_fire)
            out_val_reg <= field;
      end
   end

`ifdef GET_BIT_LZC_EN
   logic [MAX_FIELD-1:0] peek_next;
   logic [5:0]           lz_cnt;
   logic [5:0]           lz_limit;
   logic [5:0]           lzc_next;

   // Leading-zero count of the next window.
   // The scan runs upward, so the highest set bit is written last and wins.
   // Bits below fill are zero, so clamping the count to the valid-bit limit
   // gives the required saturation.
   always_comb begin
      peek_next = buf_next[BUF_BITS-1 -: MAX_FIELD];
      lz_cnt    = 6'(MAX_FIELD);
      for (int i = 0; i < MAX_FIELD; i++) begin
         if (peek_next[i])
            lz_cnt = 6'(MAX_FIELD - 1 - i);
      end
      lz_limit = (fill_next >= 7'(MAX_FIELD)) ? 6'(MAX_FIELD) : fill_next[5:0];
      lzc_next = (lz_cnt < lz_limit) ? lz_cnt : lz_limit;
   end

   // lzc is registered together with the buffer, so it always matches peek.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         lzc_reg <= 6'd0;
      else
         lzc_reg <= lzc_next;
   end
`else
   assign lzc_reg = 6'd0;
`endif

   assign peek      = buf_reg[BUF_BITS-1 -: MAX_FIELD];
   assign fill      = fill_reg;
   assign out_valid = out_valid_reg;
   assign out_val   = out_val_reg;
   assign err       = err_reg;
   assign lzc       = lzc_reg;

   // The fill level must never go above the buffer depth. It must never be
   // driven below zero by a consume or above the depth by an append.
   a_fill_max: assert property (@(posedge clock) disable iff (reset)
      fill_reg <= 7'(BUF_BITS));
   a_no_underflow: assert property (@(posedge clock) disable iff (reset)
      req_fire |-> (fill_reg >= {1'b0, req_size}));
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      byte_fire |-> (fill_after <= 7'(BUF_BITS - 8)));

endmodule

// File: tb/tb_get_bit.sv
// -----------------------------------------------------------------------------
// tb_get_bit : directed scoreboard bench for get_bit.
// Stimulus pushes each expected field into exp_q when it issues a request.
// A separate monitor pops and compares on every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_get_bit;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        req_valid;
   logic [5:0]  req_size;
   logic        req_ready;
   logic        out_valid;
   logic [31:0] out_val;
   logic [31:0] peek;
   logic [6:0]  fill;
   logic        err;
   logic [5:0]  lzc;

   int          vectors;
   int          miscompares;
   logic [31:0] exp_q[$];

   get_bit #(.BUF_BITS(64), .MAX_FIELD(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_byte   (in_byte),
      .in_ready  (in_ready),
      .req_valid (req_valid),
      .req_size  (req_size),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_val   (out_val),
      .peek      (peek),
      .fill      (fill),
      .err       (err),
      .lzc       (lzc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Monitor: every out_valid pulse must match the oldest expected field.
   always @(negedge clock) begin
      if (!reset && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got 0x%08h, expected no output", out_val);
         end else begin
            check("out_val", out_val, exp_q.pop_front());
         end
      end
   end

   // Tasks start and end at a negedge.
   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_byte  = b;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic request(input logic [5:0] size, input logic [31:0] exp);
      int n;
      req_valid = 1'b1;
      req_size  = size;
      n = 0;
      #1;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (n >= 20) begin
         check("req_ready_timeout", 32'(req_ready), 32'd1);
      end else begin
         exp_q.push_back(exp);
      end
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      req_valid = 1'b0;
      req_size  = 6'd8;

      // Reset state.
      @(negedge clock);
      @(negedge clock);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_fill", 32'(fill), 32'd0);
      check("rst_peek", peek, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_lzc", 32'(lzc), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Back-to-back mixed-size fields.
      push_byte(8'hA5);
      push_byte(8'h3C);
      check("t1_fill16", 32'(fill), 32'd16);
      check("t1_peek", peek, 32'hA53C0000);
      request(6'd4, 32'h0000000A);
      request(6'd8, 32'h00000053);
      request(6'd4, 32'h0000000C);
      @(negedge clock);
      check("t1_fill0", 32'(fill), 32'd0);

      // A request larger than fill stalls until a byte arrives.
      push_byte(8'h12);
      push_byte(8'h34);
      push_byte(8'h56);
      check("t2_fill24", 32'(fill), 32'd24);
      req_valid = 1'b1;
      req_size  = 6'd32;
      #1;
      check("t2_stall_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      check("t2_stall_no_out", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_byte  = 8'h78;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      check("t2_ready_after", 32'(req_ready), 32'd1);
      exp_q.push_back(32'h12345678);
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check("t2_fill0", 32'(fill), 32'd0);

      // Full buffer.
      for (int i = 0; i < 8; i++) push_byte(8'hFF);
      check("t3_fill64", 32'(fill), 32'd64);
      check("t3_in_ready0", 32'(in_ready), 32'd0);
      check("t3_lzc_ones", 32'(lzc), 32'd0);
      request(6'd8, 32'h000000FF);
      check("t3_fill56", 32'(fill), 32'd56);
      check("t3_in_ready1", 32'(in_ready), 32'd1);
      request(6'd32, 32'hFFFFFFFF);
      request(6'd24, 32'h00FFFFFF);
      @(negedge clock);
      check("t3_fill0", 32'(fill), 32'd0);

      // Byte and request accepted in the same cycle.
      push_byte(8'h5A);
      push_byte(8'hC3);
      in_valid  = 1'b1;
      in_byte   = 8'hAA;
      req_valid = 1'b1;
      req_size  = 6'd8;
      exp_q.push_back(32'h0000005A);
      @(posedge clock);
      @(negedge clock);
      in_valid  = 1'b0;
      req_valid = 1'b0;
      check("t4_fill16", 32'(fill), 32'd16);
      check("t4_peek", peek, 32'hC3AA0000);
      // The same cycle again with flush: everything is discarded.
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_byte   = 8'hBB;
      req_valid = 1'b1;
      req_size  = 6'd8;
      #1;
      check("t4_flush_req_ready", 32'(req_ready), 32'd0);
      @(posedge clock);
      @(negedge clock);
      flush     = 1'b0;
      in_valid  = 1'b0;
      req_valid = 1'b0;
      check("t4_flush_fill", 32'(fill), 32'd0);
      check("t4_flush_peek", peek, 32'd0);
      check("t4_flush_out_valid", 32'(out_valid), 32'd0);

      // Illegal sizes set a sticky err. flush clears it.
      push_byte(8'h81);
      req_valid = 1'b1;
      req_size  = 6'd0;
      @(posedge clock);
      @(negedge clock);
      check("t5_err_size0", 32'(err), 32'd1);
      req_size = 6'd33;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      check("t5_err_size33", 32'(err), 32'd1);
      check("t5_fill_kept", 32'(fill), 32'd8);
      @(negedge clock);
      check("t5_err_held", 32'(err), 32'd1);
      flush = 1'b1;
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0;
      check("t5_err_cleared", 32'(err), 32'd0);

      // Optional leading-zero count.
      push_byte(8'h00);
      push_byte(8'h1F);
      check("t6_peek", peek, 32'h001F0000);
`ifdef GET_BIT_LZC_EN
      check("t6_lzc", 32'(lzc), 32'd11);
`else
      check("t6_lzc", 32'(lzc), 32'd0);
`endif
      request(6'd16, 32'h0000001F);

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 5; i++) push_byte(8'h3C);
      check("t7_fill40", 32'(fill), 32'd40);
      req_valid = 1'b0;
      req_size  = 6'd8;
      #2;
      reset = 1'b1;
      #1;
      check("t7_fill", 32'(fill), 32'd0);
      check("t7_peek", peek, 32'd0);
      check("t7_out_val", out_val, 32'd0);
      check("t7_out_valid", 32'(out_valid), 32'd0);
      check("t7_err", 32'(err), 32'd0);
      check("t7_lzc", 32'(lzc), 32'd0);
      check("t7_req_ready", 32'(req_ready), 32'd0);
      check("t7_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      check("pending_fields", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/get_bit.md
Name: get_bit

Overview:
- MSB-first bitstream reader: the decode-side counterpart of the encoder's bit packer.
- Accepts a byte stream and serves variable-length fields of 1..32 bits on request.
- Exposes a 32-bit look-ahead window so downstream DC/AC Rice/exp-Golomb decoders can size their next request.
- Sits between the slice byte source and the entropy decoders.

Parameters:
- BUF_BITS, 64, internal bit buffer depth; a multiple of 8 and at least 40.
- MAX_FIELD, 32, largest field size per request; also the look-ahead window width.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous discard of all buffered bits (slice start / byte realign)
- in_valid  in  1  in_byte is valid
- in_byte  in  8  next stream byte; bit 7 is consumed first
- in_ready  out  1  buffer can accept a byte this cycle
- req_valid  in  1  field request
- req_size  in  6  field length in bits, legal 1..32
- req_ready  out  1  request will be accepted this cycle
- out_valid  out  1  one-cycle pulse; out_val holds the field
- out_val  out  32  field, right-aligned, zero-extended
- peek  out  32  next 32 unread bits, MSB-aligned; bits beyond fill are 0
- fill  out  7  count of buffered unread bits, 0..BUF_BITS
- err  out  1  sticky illegal-request flag
- lzc  out  6  leading-zero count of peek (optional feature)

Behaviour:
- Reset (async): buffer, fill, out_valid, out_val, err and lzc go to 0. in_ready is 1 and req_ready is 0 while in reset.
- Buffer is MSB-first; fill counts unread bits.
- in_ready = (fill <= BUF_BITS-8), combinational from registered fill. It does not anticipate a same-cycle consume.
- Byte accept: in_valid & in_ready. The byte is appended immediately after the last unread bit; fill += 8.
- req_ready = (fill >= req_size) & (req_size in 1..32) & !flush.
- Request accept: req_valid & req_ready.
  - The next req_size bits are removed.
  - Next cycle: out_val = those bits and out_valid = 1 (latency 1).
  - Otherwise out_valid = 0 and out_val holds its last value.
- Simultaneous byte accept and request accept: both take effect.
  - fill_next = fill - req_size + 8.
  - The consumed field comes only from bits buffered before this cycle; the new byte lands after the remaining bits.
- Underflow: req_valid with fill < req_size is stalled (not accepted). The requester holds req_valid and req_size stable until accepted.
- Illegal size: req_valid with req_size 0 or >32 is never accepted and sets err. err clears only on reset or flush.
- flush priority: flush > request > byte.
  - fill_next = 0 and the buffer is cleared.
  - A same-cycle byte is dropped.
  - out_valid = 0 next cycle; err clears.
- peek, fill and lzc are registered views of the current buffer and update the cycle after any accept or flush.
- Full: at fill = BUF_BITS, in_ready = 0. It returns to 1 the cycle after a request brings fill to BUF_BITS-8 or below.
- No wrap hazards: fill never exceeds BUF_BITS and never goes below 0. Assertions are required on both bounds.

Optional Feature:
- Macro: GET_BIT_LZC_EN.
- Defined: lzc = number of leading zeros in peek, counted only over valid bits, saturating at min(fill, 32).
  - lzc is valid when it is < fill, or when fill >= 32.
  - It is registered alongside peek.
- Undefined: the lzc port exists and is tied to 0; no counter logic is built.

Test Plan:
- Bytes 0xA5, 0x3C; requests of size 4, 8, 4 -> out_val 0xA, 0x53, 0xC on consecutive out_valid pulses; fill ends at 0.
- Bytes 0x12, 0x34, 0x56 (fill 24); request size 32 -> req_ready 0, stalled. Then byte 0x78 -> request accepted next cycle, out_val 0x12345678, fill 0.
- Push 8 bytes 0xFF -> fill 64, in_ready 0. Request 8 -> out_val 0xFF; next cycle fill 56, in_ready 1.
- fill 16 with byte 0xAA offered and request size 8 in the same cycle -> out_val equals the first buffered byte, fill 16. Repeat with flush also asserted -> fill 0, out_valid 0, byte dropped.
- Request size 0, then size 33 -> no out_valid, err 1 and held. flush -> err 0. Assert reset mid-stream with fill 40 -> all outputs 0 immediately.
- GET_BIT_LZC_EN: bytes 0x00, 0x1F -> lzc 11, peek 0x001F0000. Without the macro -> lzc 0.
